// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader and its neighbours.
//   - default geometry of the instruction memory (address width, word width, depth)
//   - frame start byte
//   - loader FSM state encoding
//   - helper that decides whether a COUNT byte describes a loadable frame
package program_loader_pkg;

  localparam int          ADDR_W_DEF = 4;
  localparam int          INST_W_DEF = 16;
  localparam int          DEPTH_DEF  = 16;
  localparam logic [7:0]  SYNC_DEF   = 8'hA5;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SYNC,
    ST_COUNT,
    ST_HI,
    ST_LO,
    ST_WRITE,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_t;

  // A frame must carry at least one word and no more words than the memory holds.
  function automatic logic count_valid(input logic [7:0] cnt, input int depth);
    return (cnt != 8'd0) && (int'(cnt) <= depth);
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Bundle of the loader's byte-stream input, program-RAM write port and status.
//   master : the environment (byte source, RAM, CPU control) - drives start/rx_*
//   slave  : the loader - drives rx_ready, mem_*, cpu_hold, done, err
// Signals:
//   start      1-cycle pulse arming the loader
//   rx_data    incoming byte, rx_valid qualifies it, rx_ready accepts it
//   mem_we     1-cycle RAM write strobe with mem_addr / mem_wdata
//   cpu_hold   CPU held in reset while loading or after a failure
//   done / err level status of the last frame
interface program_loader_if
  import program_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INST_W = INST_W_DEF
) ();

  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [INST_W-1:0] mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;

  modport master (
    output start, rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err
  );

  modport slave (
    input  start, rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err
  );

endinterface

// File: rtl/program_loader_xor_checksum.sv
// Running XOR of a byte stream.
// Ports:
//   clk     clock
//   rst_n   synchronous reset, active low (accumulator to 0)
//   clr_i   synchronous clear, takes priority over en_i
//   en_i    fold byte_i into the accumulator this cycle
//   byte_i  byte to accumulate
//   acc_o   registered accumulator
module xor_checksum (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [7:0] byte_i,
  output logic [7:0] acc_o
);

  logic [7:0] acc_q;

  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      acc_q <= 8'h00;
    end else if (en_i) begin
      acc_q <= acc_q ^ byte_i;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/program_loader.sv
// Byte-stream loader for the instruction memory.
// Frame: SYNC, COUNT N (1..DEPTH), N x {hi, lo}, CHK (XOR of the 2N instruction bytes).
// Ports:
//   clk    system clock
//   rst_n  synchronous reset, active low
//   bus    program_loader_if.slave: start, rx_data/rx_valid/rx_ready byte stream,
//          mem_we/mem_addr/mem_wdata RAM write port, cpu_hold/done/err status.
// All outputs are registered. Words are written in order from address 0; the
// address counter stops at N-1 so it never wraps.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int         ADDR_W = ADDR_W_DEF,
  parameter int         INST_W = INST_W_DEF,
  parameter int         DEPTH  = DEPTH_DEF,
  parameter logic [7:0] SYNC   = SYNC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  program_loader_if.slave  bus
);

  state_t            state_q;
  logic              rx_ready_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [INST_W-1:0] mem_wdata_q;
  logic              cpu_hold_q;
  logic              done_q;
  logic              err_q;
  logic [7:0]        hi_q;
  logic [ADDR_W:0]   n_q;      // words announced by COUNT (up to DEPTH)
  logic [ADDR_W:0]   wcnt_q;   // words written so far

  logic              hs;
  logic              armable;
  logic              chk_clr;
  logic              chk_en;
  logic [7:0]        chk;

  assign hs      = bus.rx_valid & rx_ready_q;
  assign armable = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERROR);
  assign chk_clr = armable & bus.start;
  assign chk_en  = hs & ((state_q == ST_HI) || (state_q == ST_LO));

  xor_checksum u_chk (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (chk_clr),
    .en_i   (chk_en),
    .byte_i (bus.rx_data),
    .acc_o  (chk)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rx_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      n_q         <= '0;
      wcnt_q      <= '0;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          // rx_ready is low here, so a byte offered alongside start waits for SYNC.
          if (bus.start) begin
            state_q    <= ST_SYNC;
            rx_ready_q <= 1'b1;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            mem_addr_q <= '0;
            wcnt_q     <= '0;
          end
        end
        ST_SYNC: begin
          if (hs && (bus.rx_data == SYNC)) begin
            state_q <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (hs) begin
            if (count_valid(bus.rx_data, DEPTH)) begin
              n_q     <= (ADDR_W+1)'(bus.rx_data);
              state_q <= ST_HI;
            end else begin
              state_q    <= ST_ERROR;
              rx_ready_q <= 1'b0;
              err_q      <= 1'b1;
            end
          end
        end
        ST_HI: begin
          if (hs) begin
            hi_q    <= bus.rx_data;
            state_q <= ST_LO;
          end
        end
        ST_LO: begin
          // The strobe is raised here so it is high for exactly the WRITE cycle.
          if (hs) begin
            mem_wdata_q <= INST_W'({hi_q, bus.rx_data});
            mem_we_q    <= 1'b1;
            rx_ready_q  <= 1'b0;
            state_q     <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          rx_ready_q <= 1'b1;
          wcnt_q     <= wcnt_q + 1'b1;
          if ((wcnt_q + 1'b1) < n_q) begin
            mem_addr_q <= mem_addr_q + 1'b1;
            state_q    <= ST_HI;
          end else begin
            state_q <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (hs) begin
            rx_ready_q <= 1'b0;
            if (bus.rx_data == chk) begin
              state_q    <= ST_DONE;
              done_q     <= 1'b1;
              cpu_hold_q <= 1'b0;
            end else begin
              state_q <= ST_ERROR;
              err_q   <= 1'b1;
            end
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          rx_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rx_ready  = rx_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cpu_hold  = cpu_hold_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule
